// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Uses a valid/ready handshake. Per-frame settings are captured on accept, and the serial pin is driven from a flop.
module uart_tx_frame #(
  parameter int CLK_FREQ = 50000000,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              uart_tx,
  output logic              tx_done,
  output logic              busy
);

  localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / 9600   - 1);
  localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / 19200  - 1);
  localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / 38400  - 1);
  localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / 57600  - 1);
  localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / 115200 - 1);
  localparam logic [15:0] DIV_230400 = 16'(CLK_FREQ / 230400 - 1);
  localparam logic [15:0] DIV_460800 = 16'(CLK_FREQ / 460800 - 1);
  localparam logic [15:0] DIV_921600 = 16'(CLK_FREQ / 921600 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [15:0]         div_sel, div_q, bit_cnt;
  logic [DATA_W-1:0]   sh_q;
  logic [3:0]          bit_idx;
  logic                par_en_q, par_bit_q, stop2_q;
  logic                tx_d, done_d;
  logic                accept, bit_end, last_data, last_stop;

  assign accept    = tx_valid && (state_q == IDLE);
  assign bit_end   = (bit_cnt == '0);
  assign last_data = (bit_idx == 4'(DATA_W - 1));
  assign last_stop = (bit_idx[0] == stop2_q);
  assign tx_ready  = (state_q == IDLE);
  assign busy      = ~tx_ready;

  always_comb begin
    case (baud_set)
      3'd0:    div_sel = DIV_9600;
      3'd1:    div_sel = DIV_19200;
      3'd2:    div_sel = DIV_38400;
      3'd3:    div_sel = DIV_57600;
      3'd4:    div_sel = DIV_115200;
      3'd5:    div_sel = DIV_230400;
      3'd6:    div_sel = DIV_460800;
      default: div_sel = DIV_921600;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_valid) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_d is the level the line takes on the next edge, so the pin itself stays a plain flop.
  always_comb begin
    tx_d   = uart_tx;
    done_d = 1'b0;
    case (state_q)
      IDLE:   tx_d = ~tx_valid;
      START:  if (bit_end) tx_d = sh_q[0];
      DATA:   if (bit_end) tx_d = last_data ? (par_en_q ? par_bit_q : 1'b1) : sh_q[1];
      PARITY: if (bit_end) tx_d = 1'b1;
      STOP: begin
        if (bit_end) begin
          tx_d   = 1'b1;
          done_d = last_stop;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      uart_tx <= tx_d;
      tx_done <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      bit_cnt   <= '0;
      sh_q      <= '0;
      bit_idx   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      div_q     <= div_sel;
      bit_cnt   <= div_sel;
      sh_q      <= tx_data;
      bit_idx   <= '0;
      par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_q <= (^tx_data) ^ (parity_mode == 2'b01);
      stop2_q   <= stop2;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        bit_cnt <= div_q;
        if (state_q == DATA) begin
          if (last_data) begin
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            sh_q    <= sh_q >> 1;
          end
        end else if (state_q == STOP) begin
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        bit_cnt <= bit_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. A frame-level model predicts the line, the handshake and the done pulse
// on every cycle, and directed frames are checked against hand-computed bit patterns and lengths.
module tb_uart_tx_frame;
  localparam int CLK = 50000000;
  localparam int DW  = 8;

  logic          clk, rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;
  logic [2:0]    baud_set;
  logic [1:0]    parity_mode;
  logic          stop2, uart_tx, tx_done, busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_tx_frame #(.CLK_FREQ(CLK), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
    .uart_tx(uart_tx), .tx_done(tx_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic int baud_rate(input logic [2:0] s);
    case (s)
      3'd0: return 9600;    3'd1: return 19200;
      3'd2: return 38400;   3'd3: return 57600;
      3'd4: return 115200;  3'd5: return 230400;
      3'd6: return 460800;  default: return 921600;
    endcase
  endfunction

  // Line levels in transmission order: bit 0 is the start bit, trailing ones cover the stop bits.
  function automatic logic [15:0] frame_bits(input logic [DW-1:0] d, input logic [1:0] pm);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[i+1] = d[i];
    if (pm == 2'b01 || pm == 2'b10) b[DW+1] = (^d) ^ (pm == 2'b01);
    return b;
  endfunction

  function automatic int frame_nbits(input logic [1:0] pm, input logic s2);
    return 1 + DW + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (s2 ? 2 : 1);
  endfunction

  logic        m_active, m_done;
  logic [15:0] m_bits;
  int          m_t, m_n, m_div;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_t + 1 == m_n * (m_div + 1)) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
        m_t <= m_t + 1;
      end else if (tx_valid) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_bits   <= frame_bits(tx_data, parity_mode);
        m_n      <= frame_nbits(parity_mode, stop2);
        m_div    <= CLK / baud_rate(baud_set) - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk_bit("uart_tx", uart_tx, m_active ? m_bits[m_t / (m_div + 1)] : 1'b1);
    chk_bit("tx_ready", tx_ready, ~m_active);
    chk_bit("busy", busy, m_active);
    chk_bit("tx_done", tx_done, m_done);
    if (tx_done === 1'b1) done_cnt++;
  end

  // Sends one frame, samples each bit at its centre and measures accept-to-done latency.
  task automatic send_check(input string nm, input logic [DW-1:0] d, input logic [2:0] bs,
                            input logic [1:0] pm, input logic s2, input int div, input int nb,
                            input logic [11:0] exp_bits, input bit mid_chg);
    int n;
    logic [11:0] got;
    logic [11:0] mask;
    got  = '0;
    mask = 12'((1 << nb) - 1);
    @(negedge clk);
    tx_data = d; baud_set = bs; parity_mode = pm; stop2 = s2; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (tx_done !== 1'b1 && n < nb * (div + 1) + 20) begin
      if (n % (div + 1) == div / 2 && n / (div + 1) < 12) got[n / (div + 1)] = uart_tx;
      if (mid_chg && n == 3 * (div + 1)) begin
        tx_data = ~d; baud_set = ~bs; parity_mode = ~pm; stop2 = ~s2; tx_valid = 1'b1;
      end
      if (mid_chg && n == 5 * (div + 1)) tx_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk_int({nm, " length"}, n, nb * (div + 1));
    chk_int({nm, " bits"}, int'(got & mask), int'(exp_bits));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_n, fall_n, dc;
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; baud_set = '0; parity_mode = '0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (100) @(negedge clk);
    chk_bit("idle uart_tx", uart_tx, 1'b1);
    chk_bit("idle tx_ready", tx_ready, 1'b1);
    chk_bit("idle busy", busy, 1'b0);
    chk_int("idle done pulses", done_cnt, 0);

    send_check("a5_8n1",   8'hA5, 3'd4, 2'b00, 1'b0, 433,  10, 12'h34A, 1'b0);
    send_check("07_even2", 8'h07, 3'd0, 2'b10, 1'b1, 5207, 12, 12'hE0E, 1'b0);
    send_check("07_odd1",  8'h07, 3'd7, 2'b01, 1'b0, 53,   11, 12'h40E, 1'b0);

    // Back-to-back: valid held across the done cycle.
    @(negedge clk);
    tx_data = 8'h55; baud_set = 3'd7; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hAA;
    dc = done_cnt;
    n = 0;
    while (tx_done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    done_n = n;
    while (uart_tx !== 1'b0 && n < done_n + 10) begin @(negedge clk); n++; end
    fall_n = n;
    tx_valid = 1'b0;
    chk_int("b2b first length", done_n, 540);
    chk_int("b2b stop-to-start gap", fall_n - (done_n - 54), 55);
    n = 0;
    while (tx_done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk_int("b2b second length", n, 540);
    @(negedge clk);
    chk_int("b2b done pulses", done_cnt - dc, 2);

    send_check("5a_midchg", 8'h5A, 3'd7, 2'b00, 1'b0, 53,  10, 12'h2B4, 1'b1);
    send_check("c3_newcfg", 8'hC3, 3'd6, 2'b01, 1'b1, 107, 12, 12'hF86, 1'b0);

    // Reset in the middle of data bit 3.
    @(negedge clk);
    tx_data = 8'h96; baud_set = 3'd7; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * 54 + 20) @(negedge clk);
    dc = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk_bit("async rst uart_tx", uart_tx, 1'b1);
    chk_bit("async rst tx_ready", tx_ready, 1'b1);
    chk_bit("async rst busy", busy, 1'b0);
    chk_bit("async rst tx_done", tx_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_int("abandoned frame done pulses", done_cnt - dc, 0);

    send_check("3c_after_rst", 8'h3C, 3'd7, 2'b00, 1'b0, 53, 10, 12'h278, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
